// File: rtl/data_memory_pkg.sv
// Shared defaults and FSM state encoding for the line-granular data memory model.
package data_memory_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_LINE_WIDTH = 256;
  localparam int DEF_MEM_DEPTH  = 512;
  localparam int DEF_LATENCY    = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_memory_if.sv
// Request/acknowledge bus between the data cache refill/write-back port and main memory.
interface data_memory_if
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
);
  logic [ADDR_WIDTH-1:0] addr_i;
  logic [LINE_WIDTH-1:0] data_i;
  logic                  enable_i;
  logic                  write_i;
  logic                  ack_o;
  logic [LINE_WIDTH-1:0] data_o;

  modport master (
    output addr_i, data_i, enable_i, write_i,
    input  ack_o, data_o
  );

  modport slave (
    input  addr_i, data_i, enable_i, write_i,
    output ack_o, data_o
  );
endinterface

// File: rtl/data_memory.sv
// Fixed-latency main data memory: whole-line reads/writes, one ack pulse LATENCY edges after accept.
module data_memory
  import data_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input logic          clk_i,
  input logic          rst_i,
  data_memory_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY);

  logic [LINE_WIDTH-1:0] memory [0:MEM_DEPTH-1];

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [LINE_WIDTH-1:0] rdata_q;
  logic                  accept, complete;

  logic [IDX_W-1:0]      idx_q;
  logic                  we_q;
  logic [LINE_WIDTH-1:0] wdata_q;

  logic [IDX_W-1:0]      idx_in;
  logic                  unused_addr_bits;

  // Only the line index bits select storage; higher bits alias, byte offset is irrelevant.
  assign idx_in           = bus.addr_i[OFF_W +: IDX_W];
  assign unused_addr_bits = ^{bus.addr_i[ADDR_WIDTH-1:OFF_W+IDX_W], bus.addr_i[OFF_W-1:0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ack_d    = 1'b0;
    accept   = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.enable_i) begin
          accept  = 1'b1;
          cnt_d   = CNT_W'(1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          complete = 1'b1;
          ack_d    = 1'b1;
          cnt_d    = '0;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // Dead cycle: enable_i is ignored so a held request is not re-accepted immediately.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      if (complete && !we_q)
        rdata_q <= memory[idx_q];
    end
  end

  // Request fields are captured at accept; the array itself is never cleared.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_q   <= idx_in;
      we_q    <= bus.write_i;
      wdata_q <= bus.data_i;
    end
    if (complete && we_q)
      memory[idx_q] <= wdata_q;
  end

  assign bus.ack_o  = ack_q;
  assign bus.data_o = rdata_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, read/write latency, held/dropped enable, aliasing, back-to-back.
module tb_data_memory;
  import data_memory_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_memory_if bus ();

  data_memory dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  localparam logic [255:0] LINE1 =
    256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
  localparam logic [255:0] ECFA = {16{16'hECFA}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] pat(input int i);
    return {8{32'hC0DE_0000 + 32'(i)}};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [255:0] d, input logic w);
    bus.addr_i   = a;
    bus.data_i   = d;
    bus.write_i  = w;
    bus.enable_i = 1'b1;
  endtask

  // Counts edges after the accept edge until ack; 'already' edges have elapsed. -1 on timeout.
  task automatic count_to_ack(input int already, output int lat);
    lat = -1;
    for (int n = already + 1; n <= already + 40; n++) begin
      cycle();
      if (bus.ack_o === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic finish_access();
    bus.enable_i = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL reset_ack: got %b want 0", bus.ack_o);
    end
    checks++;
    if (bus.data_o !== 256'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", bus.data_o);
    end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_read();
    int lat;
    issue(32'h20, 256'h0, 1'b0);
    cycle();
    count_to_ack(0, lat);
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL read_latency: got %0d want 10", lat);
    end
    checks++;
    if (bus.data_o !== LINE1) begin
      errors++; $display("FAIL read_data: got %h want %h", bus.data_o, LINE1);
    end
    finish_access();
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL read_ack_width: got %b want 0", bus.ack_o);
    end
    cycle();
    checks++;
    if (bus.data_o !== LINE1) begin
      errors++; $display("FAIL read_data_hold: got %h want %h", bus.data_o, LINE1);
    end
  endtask

  task automatic test_write();
    int lat;
    issue(32'h400, ECFA, 1'b1);
    cycle();
    count_to_ack(0, lat);
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL write_latency: got %0d want 10", lat);
    end
    finish_access();
    checks++;
    if (dut.memory[32] !== ECFA) begin
      errors++; $display("FAIL write_line32: got %h want %h", dut.memory[32], ECFA);
    end
    checks++;
    if (dut.memory[31] !== pat(31)) begin
      errors++; $display("FAIL write_line31: got %h want %h", dut.memory[31], pat(31));
    end
    checks++;
    if (dut.memory[33] !== pat(33)) begin
      errors++; $display("FAIL write_line33: got %h want %h", dut.memory[33], pat(33));
    end
    checks++;
    if (bus.data_o !== LINE1) begin
      errors++; $display("FAIL write_data_o_kept: got %h want %h", bus.data_o, LINE1);
    end
  endtask

  task automatic test_reset_mid_write();
    int acks;
    issue(32'hA0, {8{32'hDEAD_BEEF}}, 1'b1);
    cycle();
    for (int i = 0; i < 4; i++) cycle();
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.ack_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_ack: got %b want 0", bus.ack_o);
    end
    checks++;
    if (bus.data_o !== 256'h0) begin
      errors++; $display("FAIL rst_mid_data: got %h want 0", bus.data_o);
    end
    bus.enable_i = 1'b0;
    cycle();
    cycle();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (bus.ack_o === 1'b1) acks++;
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL rst_mid_no_ack: got %0d acks want 0", acks);
    end
    checks++;
    if (dut.memory[5] !== pat(5)) begin
      errors++; $display("FAIL rst_mid_line5: got %h want %h", dut.memory[5], pat(5));
    end
  endtask

  task automatic test_held_enable();
    int acks, a1, a2, a3;
    acks = 0; a1 = -1; a2 = -1; a3 = -1;
    issue(32'h60, 256'h0, 1'b0);
    cycle();
    for (int n = 1; n <= 34; n++) begin
      cycle();
      if (bus.ack_o === 1'b1) begin
        if (acks == 0) a1 = n;
        else if (acks == 1) a2 = n;
        else a3 = n;
        acks++;
      end
    end
    finish_access();
    checks++;
    if (a1 !== 10) begin
      errors++; $display("FAIL held_first_ack: got %0d want 10", a1);
    end
    checks++;
    if (a2 !== 22) begin
      errors++; $display("FAIL held_second_ack: got %0d want 22", a2);
    end
    checks++;
    if (acks !== 3 || a3 !== 34) begin
      errors++; $display("FAIL held_ack_count: got %0d acks last %0d want 3 acks last 34", acks, a3);
    end
    checks++;
    if (bus.data_o !== pat(3)) begin
      errors++; $display("FAIL held_data: got %h want %h", bus.data_o, pat(3));
    end
  endtask

  task automatic test_enable_drop();
    int lat;
    issue(32'hE0, 256'h0, 1'b0);
    cycle();
    for (int i = 0; i < 3; i++) cycle();
    bus.enable_i = 1'b0;
    bus.addr_i   = 32'h20;
    bus.write_i  = 1'b1;
    bus.data_i   = {8{32'h0BAD_F00D}};
    count_to_ack(3, lat);
    checks++;
    if (lat !== 10) begin
      errors++; $display("FAIL drop_latency: got %0d want 10", lat);
    end
    checks++;
    if (bus.data_o !== pat(7)) begin
      errors++; $display("FAIL drop_data: got %h want %h", bus.data_o, pat(7));
    end
    finish_access();
    checks++;
    if (dut.memory[1] !== LINE1) begin
      errors++; $display("FAIL drop_line1_kept: got %h want %h", dut.memory[1], LINE1);
    end
    checks++;
    if (dut.memory[7] !== pat(7)) begin
      errors++; $display("FAIL drop_line7_kept: got %h want %h", dut.memory[7], pat(7));
    end
  endtask

  task automatic test_alias();
    int lat;
    issue(32'h4040, 256'h0, 1'b0);
    cycle();
    count_to_ack(0, lat);
    finish_access();
    checks++;
    if (bus.data_o !== pat(2)) begin
      errors++; $display("FAIL alias_4040: got %h want %h", bus.data_o, pat(2));
    end
    issue(32'h7F, 256'h0, 1'b0);
    cycle();
    count_to_ack(0, lat);
    finish_access();
    checks++;
    if (bus.data_o !== pat(3)) begin
      errors++; $display("FAIL alias_007F: got %h want %h", bus.data_o, pat(3));
    end
    issue(32'hC05F, 256'h0, 1'b0);
    cycle();
    count_to_ack(0, lat);
    finish_access();
    checks++;
    if (bus.data_o !== pat(2)) begin
      errors++; $display("FAIL alias_C05F: got %h want %h", bus.data_o, pat(2));
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    issue(32'h500, {8{32'h1234_5678}}, 1'b1);
    cycle();
    count_to_ack(0, lat1);
    bus.addr_i  = 32'h520;
    bus.write_i = 1'b0;
    count_to_ack(0, lat2);
    finish_access();
    checks++;
    if (lat1 !== 10) begin
      errors++; $display("FAIL b2b_write_latency: got %0d want 10", lat1);
    end
    checks++;
    if (lat2 !== 12) begin
      errors++; $display("FAIL b2b_read_gap: got %0d want 12", lat2);
    end
    checks++;
    if (dut.memory[40] !== {8{32'h1234_5678}}) begin
      errors++; $display("FAIL b2b_line40: got %h want %h", dut.memory[40], {8{32'h1234_5678}});
    end
    checks++;
    if (bus.data_o !== pat(41)) begin
      errors++; $display("FAIL b2b_read_data: got %h want %h", bus.data_o, pat(41));
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.addr_i   = '0;
    bus.data_i   = '0;
    bus.enable_i = 1'b0;
    bus.write_i  = 1'b0;
    for (int i = 0; i < DEF_MEM_DEPTH; i++) dut.memory[i] = pat(i);
    dut.memory[1] = LINE1;

    test_reset();
    test_read();
    test_write();
    test_reset_mid_write();
    test_held_enable();
    test_enable_drop();
    test_alias();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
